sfx_scheduler: RTL and testbench
================================

Name: sfx_scheduler

Overview:
- Sound-effect scheduler for the audio path. It shares the single PWM duty channel between 4 effect requesters: shot, invader step, explosion and UFO.
- Each requester asks for a square tone, given as a half-period in clk cycles and a length in half-periods.
- The block arbitrates by fixed priority, preempts lower-priority tones and drives the duty word into the downstream PWM generator.

Parameters:
- DUTY_WIDTH, 8, width of the volume and duty words; matches the PWM generator.
- PERIOD_WIDTH, 16, width of each half-period field, in clk cycles.
- LEN_WIDTH, 12, width of each tone-length field, counted in half-periods (toggles).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  audio enable; low silences output and flushes requests.
- trig  in  4  one-cycle request strobes; index 0 is highest priority.
- half_period  in  4*PERIOD_WIDTH  packed; field i = bits [i*PERIOD_WIDTH +: PERIOD_WIDTH].
- num_toggles  in  4*LEN_WIDTH  packed, same packing as half_period.
- volume  in  DUTY_WIDTH  duty value driven during the high phase; sampled live.
- duty  out  DUTY_WIDTH  to the PWM generator duty input.
- busy  out  1  high while a tone is playing.
- active_id  out  2  index of the playing tone; 0 when idle.
- done  out  4  one-cycle pulse when tone i completes normally.

Behaviour:
- Reset values: state IDLE, pending=0, phase=0, cnt=0, remaining=0, active_id=0, done=0, busy=0, duty=0. Reset mid-tone silences on the next edge, with no done pulse.
- Request vector: req = pending | trig.
  - pending[i] sets on trig[i] when the request is not started that cycle.
  - pending[i] clears when tone i starts.
- Winner: lowest set index of req.
- Start (on edge):
  - Latch hp = half_period[w] (a value of 0 is treated as 1) and rem = num_toggles[w].
  - cnt <= 0, phase <= 1, active_id <= w, state PLAY.
  - Latency: trig sampled at edge k gives duty = volume right after edge k.
- Zero length: if num_toggles[w] == 0, there is no PLAY. done[w] pulses for the cycle after the edge, the state stays IDLE and arbitration continues on the following edge.
- IDLE: if enable and req != 0, start the winner; otherwise hold.
- PLAY, each edge:
  - If cnt == hp-1: cnt <= 0, phase <= ~phase, rem <= rem-1.
  - If rem == 1 at that point: finish. Go to IDLE, phase <= 0, and pulse done[active_id] for exactly one cycle.
  - Otherwise: cnt <= cnt+1.
  - Total PLAY time = num_toggles*hp cycles: high for hp, low for hp, alternating, starting high.
- Preemption: in PLAY, if req has an index j < active_id, start j on that edge. The aborted tone is dropped (no done, not re-queued).
- Retrigger: trig[active_id] during PLAY restarts that tone with freshly latched parameters. The restart takes effect unless a higher-priority index also requests, in which case preemption wins.
- Lower-priority trig during PLAY sets pending; it plays after the current tone finishes.
- Finish and new request on the same edge: the finishing edge goes to IDLE. Arbitration happens on the next edge, so there is exactly one silent cycle between tones.
- enable low:
  - On the edge it is sampled, state <= IDLE, pending <= 0, phase <= 0, no done.
  - trig is ignored while enable is low.
- Outputs:
  - duty = (state==PLAY && phase) ? volume : 0.
  - busy = (state==PLAY).
  - done is registered.
- Arithmetic:
  - cnt is PERIOD_WIDTH bits; rem is LEN_WIDTH bits.
  - Maximum length 2^LEN_WIDTH-1 with no wrap.
  - hp = 2^PERIOD_WIDTH-1 is legal.

Test Plan:
- Basic tone: enable=1, volume=0x80, trig[2] with hp=3, toggles=4. duty must be 80,80,80,00,00,00,80,80,80,00,00,00 over the next 12 cycles. Then done[2] pulses for 1 cycle, busy falls and active_id=0.
- Priority/queue: trig[1] and trig[3] in the same cycle, hp=2, toggles=2 each.
  - Tone 1 plays 4 cycles, then done[1], then 1 idle cycle.
  - Then tone 3 plays 4 cycles, then done[3].
- Preemption: tone 3 playing (hp=5, toggles=10); trig[0] (hp=1, toggles=2) at cycle 7. active_id must become 0 on the next edge and tone 0 plays 2 cycles. done[3] must never pulse and tone 3 must not resume.
- Edge cases:
  - toggles=0 on trig[1] yields done[1] with duty held at 0 and busy=0.
  - hp=0, toggles=2 yields 1 cycle high, 1 cycle low.
- Retrigger: tone 2 (hp=4, toggles=6) mid-low-phase; trig[2] with hp=2. duty must go high for 2 cycles from the next edge, with the count restarted at 6.
- Disruption: rst asserted mid-tone, and separately enable dropped mid-tone with a pending request.
  - Both cases: duty=0 and busy=0 after the next edge, with no done pulse.
  - In the enable case, the pending request does not play when enable returns.

Source files
------------

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: shares one PWM duty channel between four sound-effect
// requesters (0 = shot, 1 = invader step, 2 = explosion, 3 = UFO).
// Requests are arbitrated by fixed priority (index 0 highest), a higher
// priority request preempts the playing tone, and the block emits a square
// wave duty word for the downstream PWM generator.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   enable        audio enable; low silences output and flushes requests
//   trig[3:0]     one-cycle request strobes
//   half_period   packed 4 x PERIOD_WIDTH half-periods in clk cycles (0 -> 1)
//   num_toggles   packed 4 x LEN_WIDTH tone lengths in half-periods
//   volume        duty value during the high phase, used live
//   duty          duty word to the PWM generator
//   busy          high while a tone is playing
//   active_id     index of the playing tone, 0 when idle
//   done[3:0]     one-cycle pulse when tone i completes normally
module sfx_scheduler #(
  parameter int unsigned DUTY_WIDTH   = 8,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned LEN_WIDTH    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [3:0]                trig,
  input  logic [4*PERIOD_WIDTH-1:0] half_period,
  input  logic [4*LEN_WIDTH-1:0]    num_toggles,
  input  logic [DUTY_WIDTH-1:0]     volume,
  output logic [DUTY_WIDTH-1:0]     duty,
  output logic                      busy,
  output logic [1:0]                active_id,
  output logic [3:0]                done
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                  state;
  logic [3:0]              pending;
  logic                    phase;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] hp;
  logic [LEN_WIDTH-1:0]    rem;

  logic [3:0]              req;
  logic [1:0]              win;
  logic [PERIOD_WIDTH-1:0] win_hp;
  logic [LEN_WIDTH-1:0]    win_len;
  logic                    start;

  // Arbitration: lowest set request index wins, with its tone fields.
  always_comb begin
    req     = pending | trig;
    win     = 2'd0;
    win_hp  = '0;
    win_len = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        win_hp  = half_period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
        win_len = num_toggles[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
    // In PLAY only an equal index (retrigger) or a higher priority may start.
    start = enable && (|req) && ((state == IDLE) || (win <= active_id));
  end

  // Scheduler state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      phase     <= 1'b0;
      cnt       <= '0;
      hp        <= '0;
      rem       <= '0;
      active_id <= 2'd0;
      done      <= '0;
    end else begin
      done <= '0;
      if (!enable) begin
        state     <= IDLE;
        pending   <= '0;
        phase     <= 1'b0;
        cnt       <= '0;
        active_id <= 2'd0;
      end else begin
        pending <= req;
        if (start) begin
          pending[win] <= 1'b0;
          cnt          <= '0;
          if (win_len == '0) begin
            // Zero-length tone completes immediately without playing.
            state     <= IDLE;
            phase     <= 1'b0;
            active_id <= 2'd0;
            done[win] <= 1'b1;
          end else begin
            state     <= PLAY;
            phase     <= 1'b1;
            hp        <= (win_hp == '0) ? PERIOD_WIDTH'(1) : win_hp;
            rem       <= win_len;
            active_id <= win;
          end
        end else if (state == PLAY) begin
          if (cnt == hp - PERIOD_WIDTH'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
            rem   <= rem - LEN_WIDTH'(1);
            if (rem == LEN_WIDTH'(1)) begin
              state           <= IDLE;
              phase           <= 1'b0;
              active_id       <= 2'd0;
              done[active_id] <= 1'b1;
            end
          end else begin
            cnt <= cnt + PERIOD_WIDTH'(1);
          end
        end
      end
    end
  end

  // Volume is applied live so level changes take effect mid-tone.
  assign busy = (state == PLAY);
  assign duty = (busy && phase) ? volume : '0;

endmodule

// File: tb/tb_sfx_scheduler.sv
module tb_sfx_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned LW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    trig = '0;
  logic [4*PW-1:0] hp_bus = '0;
  logic [4*LW-1:0] tg_bus = '0;
  logic [DW-1:0] volume = 8'h80;
  logic [DW-1:0] duty;
  logic          busy;
  logic [1:0]    active_id;
  logic [3:0]    done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cycle  = 0;

  sfx_scheduler #(.DUTY_WIDTH(DW), .PERIOD_WIDTH(PW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .half_period(hp_bus), .num_toggles(tg_bus), .volume(volume),
    .duty(duty), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cycle, act, exp);
    end
  endtask

  // Behavioural model: a tone is "elapsed time t out of len*hp cycles",
  // high whenever (t / hp) is even.
  bit       m_play = 1'b0;
  int       m_id = 0, m_hp = 1, m_tot = 0, m_t = 0;
  bit [3:0] m_pend = '0;
  bit [3:0] m_done = '0;

  always @(posedge clk) begin
    bit [3:0] r;
    int w, h, len;
    cycle++;
    m_done = '0;
    if (rst || !enable) begin
      m_play = 1'b0;
      m_pend = '0;
      m_id   = 0;
    end else begin
      r = m_pend | trig;
      w = -1;
      for (int i = 3; i >= 0; i--) if (r[i]) w = i;
      if (w >= 0 && (!m_play || w <= m_id)) begin
        m_pend    = r;
        m_pend[w] = 1'b0;
        h   = int'(hp_bus[w*PW +: PW]);
        len = int'(tg_bus[w*LW +: LW]);
        if (h == 0) h = 1;
        if (len == 0) begin
          m_play    = 1'b0;
          m_id      = 0;
          m_done[w] = 1'b1;
        end else begin
          m_play = 1'b1;
          m_id   = w;
          m_hp   = h;
          m_tot  = len * h;
          m_t    = 0;
        end
      end else begin
        m_pend = r;
        if (m_play) begin
          if (m_t + 1 == m_tot) begin
            m_play       = 1'b0;
            m_done[m_id] = 1'b1;
            m_id         = 0;
          end else begin
            m_t++;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [DW-1:0] md;
    if (chk_en) begin
      md = (m_play && ((m_t / m_hp) % 2 == 0)) ? volume : '0;
      chk("model_duty", 32'(duty), 32'(md));
      chk("model_busy", 32'(busy), 32'(m_play));
      chk("model_active_id", 32'(active_id), 32'(m_id));
      chk("model_done", 32'(done), 32'(m_done));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_tone(input int i, input int h, input int n);
    hp_bus[i*PW +: PW] = PW'(h);
    tg_bus[i*LW +: LW] = LW'(n);
  endtask

  task automatic fire(input logic [3:0] t);
    trig = t;
    cyc();
    trig = '0;
  endtask

  initial begin
    logic [7:0] basic_exp [12];
    basic_exp = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00,
                  8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00};

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_duty", 32'(duty), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_active_id", 32'(active_id), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // Basic tone: hp=3, 4 toggles on requester 2
    enable = 1'b1;
    volume = 8'h80;
    set_tone(2, 3, 4);
    fire(4'b0100);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("basic_duty[%0d]", k), 32'(duty), 32'(basic_exp[k]));
      cyc();
    end
    chk("basic_done", 32'(done), 32'b0100);
    chk("basic_busy_fall", 32'(busy), 32'h0);
    chk("basic_id_idle", 32'(active_id), 32'h0);
    cyc();
    chk("basic_done_one_cycle", 32'(done), 32'h0);

    // Priority and queueing: 1 and 3 together
    set_tone(1, 2, 2);
    set_tone(3, 2, 2);
    fire(4'b1010);
    chk("prio_first_id", 32'(active_id), 32'd1);
    repeat (4) cyc();
    chk("prio_done1", 32'(done), 32'b0010);
    chk("prio_gap_busy", 32'(busy), 32'h0);
    cyc();
    chk("prio_second_id", 32'(active_id), 32'd3);
    repeat (4) cyc();
    chk("prio_done3", 32'(done), 32'b1000);
    cyc();

    // Preemption of tone 3 by tone 0
    set_tone(3, 5, 10);
    fire(4'b1000);
    repeat (6) cyc();
    set_tone(0, 1, 2);
    fire(4'b0001);
    chk("preempt_id", 32'(active_id), 32'd0);
    chk("preempt_duty_hi", 32'(duty), 32'h80);
    cyc();
    chk("preempt_duty_lo", 32'(duty), 32'h0);
    chk("preempt_busy", 32'(busy), 32'h1);
    cyc();
    chk("preempt_done0", 32'(done), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      chk("preempt_no_resume", 32'(busy), 32'h0);
      cyc();
    end

    // Zero length
    set_tone(1, 5, 0);
    fire(4'b0010);
    chk("zero_len_done", 32'(done), 32'b0010);
    chk("zero_len_busy", 32'(busy), 32'h0);
    chk("zero_len_duty", 32'(duty), 32'h0);
    cyc();

    // hp=0 behaves as hp=1
    set_tone(2, 0, 2);
    fire(4'b0100);
    chk("hp0_high", 32'(duty), 32'h80);
    cyc();
    chk("hp0_low", 32'(duty), 32'h0);
    cyc();
    chk("hp0_done", 32'(done), 32'b0100);
    cyc();

    // Retrigger mid-low-phase
    set_tone(2, 4, 6);
    fire(4'b0100);
    repeat (5) cyc();
    chk("retrig_pre_low", 32'(duty), 32'h0);
    set_tone(2, 2, 6);
    fire(4'b0100);
    chk("retrig_high0", 32'(duty), 32'h80);
    cyc();
    chk("retrig_high1", 32'(duty), 32'h80);
    cyc();
    chk("retrig_low", 32'(duty), 32'h0);
    repeat (12) cyc();

    // Reset mid-tone
    set_tone(3, 3, 4);
    fire(4'b1000);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_duty", 32'(duty), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    cyc();

    // Enable drop mid-tone with a pending lower-priority request
    set_tone(2, 3, 4);
    set_tone(3, 2, 2);
    fire(4'b0100);
    fire(4'b1000);
    enable = 1'b0;
    cyc();
    chk("en_drop_duty", 32'(duty), 32'h0);
    chk("en_drop_busy", 32'(busy), 32'h0);
    chk("en_drop_done", 32'(done), 32'h0);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("en_flushed_pending", 32'(busy), 32'h0);
      cyc();
    end

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        set_tone(i, int'($urandom_range(0, 6)), int'($urandom_range(0, 8)));
        trig[i] = ($urandom_range(0, 15) == 0);
      end
      volume = 8'($urandom);
      enable = ($urandom_range(0, 49) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      cyc();
    end
    trig = '0;
    rst  = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
